// File: rtl/coin_credit_front.sv
// Vending front end: coin-to-credit accounting with pay/vend handshake,
// plus a synchronized, debounced push-button press pulse.
module coin_credit_front #(
  parameter int unsigned PRICE           = 15,
  parameter int unsigned MAX_CREDIT      = 99,
  parameter int unsigned CREDIT_W        = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                refund_req,
  input  logic                vend_done,
  input  logic                button_raw,
  output logic                coin,
  output logic                button,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount,
  output logic                reject
);

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t              state;
  logic [SUM_W-1:0]    add_c;
  logic [SUM_W-1:0]    sum_wide_c;
  logic [CREDIT_W-1:0] sum_c;
  logic                reject_c;

  logic                s1, s2, deb;
  logic [CNT_W-1:0]    deb_cnt;

  // Coin decode; the extra sum bit keeps the overflow compare exact.
  always_comb begin
    add_c = '0;
    if (coin_valid) begin
      case (coin_value)
        2'd0:    add_c = SUM_W'(1);
        2'd1:    add_c = SUM_W'(5);
        2'd2:    add_c = SUM_W'(10);
        default: add_c = '0;
      endcase
    end
    sum_wide_c = SUM_W'(credit) + add_c;
    reject_c   = coin_valid && ((coin_value == 2'd3) || (sum_wide_c > SUM_W'(MAX_CREDIT)));
    sum_c      = reject_c ? credit : sum_wide_c[CREDIT_W-1:0];
  end

  // Credit / payment state machine
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      credit        <= '0;
      coin          <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
      reject        <= 1'b0;
    end else begin
      coin          <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
      reject        <= reject_c;
      case (state)
        IDLE: begin
          if (refund_req) begin
            refund_valid  <= 1'b1;
            refund_amount <= sum_c;
            credit        <= '0;
          end else if (sum_c >= CREDIT_W'(PRICE)) begin
            coin   <= 1'b1;
            credit <= sum_c - CREDIT_W'(PRICE);
            state  <= ARMED;
          end else begin
            credit <= sum_c;
          end
        end
        ARMED: begin
          if (refund_req) begin
            refund_valid  <= 1'b1;
            refund_amount <= sum_c;
            credit        <= '0;
          end else begin
            credit <= sum_c;
          end
          if (vend_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Button synchronizer and debouncer; pulse only on the debounced rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
      button  <= 1'b0;
    end else begin
      s1     <= button_raw;
      s2     <= s1;
      button <= 1'b0;
      if (s2 != deb) begin
        if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb     <= s2;
          deb_cnt <= '0;
          button  <= s2;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_coin_credit_front.sv
// Randomized self-checking bench for coin_credit_front against a
// behavioural model of credit accounting and windowed button debounce.
module tb_coin_credit_front;

  localparam int PRICE = 15;
  localparam int MAXC  = 99;
  localparam int DC    = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       refund_req;
  logic       vend_done;
  logic       button_raw;
  logic       coin;
  logic       button;
  logic [6:0] credit;
  logic       refund_valid;
  logic [6:0] refund_amount;
  logic       reject;

  coin_credit_front dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_value(coin_value),
    .refund_req(refund_req), .vend_done(vend_done), .button_raw(button_raw),
    .coin(coin), .button(button), .credit(credit), .refund_valid(refund_valid),
    .refund_amount(refund_amount), .reject(reject)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference state
  int m_credit;
  bit m_armed;
  bit m_deb;
  bit hist[0:7];
  int e_coin, e_reject, e_rv, e_ra, e_button;
  int button_pulses;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int coin_units(input logic [1:0] v);
    case (v)
      2'd0: return 1;
      2'd1: return 5;
      2'd2: return 10;
      default: return 0;
    endcase
  endfunction

  // Apply one cycle of inputs, advance the model, compare every output.
  task automatic step(input bit rst, input bit cv, input logic [1:0] cval,
                      input bit rr, input bit vd, input bit br);
    int  add, sum;
    bit  all_diff;
    reset = rst; coin_valid = cv; coin_value = cval;
    refund_req = rr; vend_done = vd; button_raw = br;
    @(posedge clk);
    e_coin = 0; e_reject = 0; e_rv = 0; e_ra = 0; e_button = 0;
    if (rst) begin
      m_credit = 0; m_armed = 0; m_deb = 0;
      for (int i = 0; i < 8; i++) hist[i] = 0;
    end else begin
      add      = cv ? coin_units(cval) : 0;
      e_reject = (cv && (cval == 2'd3 || m_credit + add > MAXC)) ? 1 : 0;
      sum      = e_reject ? m_credit : m_credit + add;
      if (rr) begin
        e_rv = 1; e_ra = sum; m_credit = 0;
        if (m_armed && vd) m_armed = 0;
      end else if (!m_armed) begin
        if (sum >= PRICE) begin
          e_coin = 1; m_credit = sum - PRICE; m_armed = 1;
        end else m_credit = sum;
      end else begin
        m_credit = sum;
        if (vd) m_armed = 0;
      end
      // debounced level flips once the synchronized input has differed for DC edges
      all_diff = 1;
      for (int j = 1; j <= DC; j++) if (hist[j] == m_deb) all_diff = 0;
      if (all_diff) begin
        if (!m_deb) e_button = 1;
        m_deb = ~m_deb;
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = br;
    end
    #1;
    check("coin", int'(coin), e_coin);
    check("reject", int'(reject), e_reject);
    check("refund_valid", int'(refund_valid), e_rv);
    if (e_rv != 0) check("refund_amount", int'(refund_amount), e_ra);
    check("credit", int'(credit), m_credit);
    check("button", int'(button), e_button);
    if (button) button_pulses++;
  endtask

  task automatic put(input logic [1:0] v);
    step(0, 1, v, 0, 0, 0);
  endtask

  task automatic idle(input int n, input bit br);
    for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0, br);
  endtask

  bit         btn_level;
  int         btn_hold;
  int         pulses_before;
  logic [1:0] rv;

  initial begin
    m_credit = 0; m_armed = 0; m_deb = 0;
    for (int i = 0; i < 8; i++) hist[i] = 0;
    button_pulses = 0;
    step(1, 0, 2'd0, 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0);
    check("reset_credit", int'(credit), 0);
    check("reset_coin", int'(coin), 0);

    // basic payment, then accumulation while armed
    put(2'd2); put(2'd1);
    check("pay_coin", int'(coin), 1);
    check("pay_credit", int'(credit), 0);
    put(2'd2);
    check("armed_credit", int'(credit), 10);
    step(0, 0, 2'd0, 0, 1, 0);
    idle(1, 0);
    check("no_refire", int'(coin), 0);
    step(0, 0, 2'd0, 1, 0, 0);

    // leftover credit re-fires on the first idle cycle
    put(2'd2); put(2'd2);
    check("left_credit", int'(credit), 5);
    put(2'd2);
    check("left_armed", int'(credit), 15);
    step(0, 0, 2'd0, 0, 1, 0);
    idle(1, 0);
    check("refire_coin", int'(coin), 1);
    check("refire_credit", int'(credit), 0);

    // reject: overflow in armed state
    for (int i = 0; i < 9; i++) put(2'd2);
    put(2'd1);
    check("credit95", int'(credit), 95);
    put(2'd2);
    check("ovf_reject", int'(reject), 1);
    check("ovf_credit", int'(credit), 95);
    put(2'd3);
    check("inv_reject", int'(reject), 1);

    // refund in armed, then combined coin+refund in idle
    step(0, 0, 2'd0, 1, 1, 0);
    check("refund95", int'(refund_amount), 95);
    put(2'd2);
    step(0, 1, 2'd1, 1, 0, 0);
    check("refund15", int'(refund_amount), 15);
    check("refund15_coin", int'(coin), 0);

    // mid-activity reset then stray vend_done
    put(2'd2);
    step(1, 0, 2'd0, 0, 0, 0);
    step(1, 0, 2'd0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 1, 0);
    check("post_reset_credit", int'(credit), 0);

    // button: short glitch, long hold, release
    idle(8, 0);
    pulses_before = button_pulses;
    idle(3, 1);
    idle(10, 0);
    check("glitch_pulses", button_pulses - pulses_before, 0);
    pulses_before = button_pulses;
    idle(5, 1);
    check("btn_early", button_pulses - pulses_before, 0);
    idle(1, 1);
    check("btn_at_e5", int'(button), 1);
    idle(6, 1);
    idle(12, 0);
    check("hold_pulses", button_pulses - pulses_before, 1);

    // randomized traffic
    btn_level = 0; btn_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (btn_hold == 0) begin
        btn_level = ~btn_level;
        btn_hold  = $urandom_range(1, 12);
      end
      btn_hold--;
      rv = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 1) == 1), rv,
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 11) == 0), btn_level);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
